// File: rtl/data_memory_responder.sv
// Doubleword data memory with a fixed-latency IDLE/WAIT/RESP handshake toward the core.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned requests on Mem_error instead of performing them.
module data_memory_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MemRead_control,
  input  logic        MemWrite_control,
  input  logic [63:0] Address,
  input  logic [63:0] Write_data,
  output logic [63:0] Read_data,
  output logic        Mem_ready,
  output logic        Mem_busy,
  output logic        Mem_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          accept, commit;
  logic          cap_write, cap_mis, err_q;
  logic [AW-1:0] cap_idx;
  logic [63:0]   cap_wdata;
  logic          live_mis;
  logic [AW-1:0] live_idx;
  logic          op_write, op_mis;
  logic [AW-1:0] op_idx;
  logic [63:0]   op_wdata;
  logic [63:0]   mem [DEPTH];
  logic          unused_addr;

  assign live_idx    = Address[AW+2:3];
  assign unused_addr = ^{Address[63:AW+3], Address[2:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign live_mis = |Address[2:0];
`else
  assign live_mis = 1'b0;
`endif

  assign accept = (state == IDLE) && (MemRead_control ^ MemWrite_control);

  // With zero wait states the commit happens on the accept edge, so use live operands there.
  assign op_write = (state == IDLE) ? MemWrite_control : cap_write;
  assign op_idx   = (state == IDLE) ? live_idx        : cap_idx;
  assign op_wdata = (state == IDLE) ? Write_data      : cap_wdata;
  assign op_mis   = (state == IDLE) ? live_mis        : cap_mis;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = RESP;
            commit    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_mis   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      err_q     <= 1'b0;
      Read_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_write <= MemWrite_control;
        cap_mis   <= live_mis;
        cap_idx   <= live_idx;
        cap_wdata <= Write_data;
      end
      if (commit) begin
        err_q <= op_mis;
        if (!op_write && !op_mis) Read_data <= mem[op_idx];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && op_write && !op_mis) begin
      mem[op_idx] <= op_wdata;
    end
  end

  assign Mem_busy  = (state != IDLE);
  assign Mem_ready = (state == RESP);
  assign Mem_error = (state == RESP) && err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_data_memory_responder;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  logic [63:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [63:0] rdata0, rdata1;
  logic        rdy0, busy0, err0, rdy1, busy1, err1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0] rd;
    bit          err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  data_memory_responder #(.DEPTH(32), .WAIT_STATES(2)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .MemRead_control(rd0), .MemWrite_control(wr0),
    .Address(addr0), .Write_data(wdata0), .Read_data(rdata0),
    .Mem_ready(rdy0), .Mem_busy(busy0), .Mem_error(err0));

  data_memory_responder #(.DEPTH(32), .WAIT_STATES(0)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .MemRead_control(rd1), .MemWrite_control(wr1),
    .Address(addr1), .Write_data(wdata1), .Read_data(rdata1),
    .Mem_ready(rdy1), .Mem_busy(busy1), .Mem_error(err1));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [63:0] a, input logic [63:0] d);
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_req(input string name, input bit sel, input bit rd, input bit wr,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] exp_rd, input bit exp_err, input int exp_lat);
    exp_t e;
    exp_t got_e;
    bit   got;
    int   lat;
    e.rd = exp_rd;
    e.err = exp_err;
    sb.push_back(e);
    drive(sel, rd, wr, a, d);
    @(posedge CLK);
    got = 0;
    lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge CLK);
      if (k == 1) drive(sel, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      if (sel ? rdy1 : rdy0) begin
        got = 1;
        lat = k;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_sb: got response expected none queued", name);
        end else begin
          got_e = sb.pop_front();
          chk({name, "_rdata"}, sel ? rdata1 : rdata0, got_e.rd);
          chk({name, "_err"}, {63'd0, sel ? err1 : err0}, {63'd0, got_e.err});
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no Mem_ready expected one within 40 cycles", name);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
      @(negedge CLK);
      chk({name, "_idle"}, {63'd0, sel ? busy1 : busy0}, 64'd0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 3};
    tbl[1] = '{1'b1, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 3};
    tbl[2] = '{1'b0, 1'b1, 64'h100, 64'h1234, 64'hDEADBEEF_CAFEF00D, 1'b0, 3};
    tbl[3] = '{1'b1, 1'b0, 64'h0, 64'h0, 64'h1234, 1'b0, 3};
    tbl[4] = '{1'b1, 1'b0, 64'h48, 64'h0, 64'h0, 1'b0, 3};
    tbl[5] = '{1'b0, 1'b1, 64'h8, 64'hAAAA, 64'h0, 1'b0, 3};
    tbl[6] = '{1'b1, 1'b0, 64'h108, 64'h0, 64'hAAAA, 1'b0, 3};
    tbl[7] = '{1'b0, 1'b1, 64'hF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA, 1'b0, 3};
    tbl[8] = '{1'b1, 1'b0, 64'hF8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3};
    tbl[9] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 3};

    #1 RESET_N = 1'b0;
    #1;
    chk("rst_rdata", rdata0, 64'h0);
    chk("rst_ready", {63'd0, rdy0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_err", {63'd0, err0}, 64'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 10; i++)
      do_req($sformatf("vec%0d", i), 1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
             tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_lat);

    // Both controls high: nothing may be accepted.
    drive(1'b0, 1'b1, 1'b1, 64'h40, 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("both_busy%0d", k), {63'd0, busy0}, 64'd0);
      chk($sformatf("both_ready%0d", k), {63'd0, rdy0}, 64'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    do_req("both_after", 1'b0, 1'b1, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 3);

`ifdef DMEM_ALIGN_CHECK_EN
    do_req("mis_store", 1'b0, 1'b0, 1'b1, 64'h43, 64'h1111, 64'hDEADBEEF_CAFEF00D, 1'b1, 3);
    do_req("mis_check", 1'b0, 1'b1, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 3);
`else
    do_req("mis_store", 1'b0, 1'b0, 1'b1, 64'h43, 64'h1111, 64'hDEADBEEF_CAFEF00D, 1'b0, 3);
    do_req("mis_check", 1'b0, 1'b1, 1'b0, 64'h40, 64'h0, 64'h1111, 1'b0, 3);
`endif

    // Reset while the store is still waiting.
    drive(1'b0, 1'b0, 1'b1, 64'h8, 64'h55);
    @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    chk("midrst_inwait", {63'd0, busy0}, 64'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_rdata", rdata0, 64'h0);
    chk("midrst_ready", {63'd0, rdy0}, 64'd0);
    chk("midrst_busy", {63'd0, busy0}, 64'd0);
    chk("midrst_err", {63'd0, err0}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("midrst_noready%0d", k), {63'd0, rdy0}, 64'd0);
    end
    RESET_N = 1'b1;
    do_req("midrst_load", 1'b0, 1'b1, 1'b0, 64'h8, 64'h0, 64'h0, 1'b0, 3);

    // Zero-wait-state instance.
    do_req("ws0_store", 1'b1, 1'b0, 1'b1, 64'h10, 64'h77, 64'h0, 1'b0, 1);
    drive(1'b1, 1'b1, 1'b0, 64'h10, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      chk($sformatf("ws0_b2b_ready%0d", k), {63'd0, rdy1}, 64'(k % 2));
      if (k % 2 == 1) chk($sformatf("ws0_b2b_rdata%0d", k), rdata1, 64'h77);
    end
    drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge CLK);
    chk("ws0_b2b_idle", {63'd0, busy1}, 64'd0);
    do_req("ws0_load", 1'b1, 1'b1, 1'b0, 64'h110, 64'h0, 64'h77, 1'b0, 1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion before 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 64-bit doublewords stored (power of two, at least 2).
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning the extra cycles inserted before a response (0..15).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port MemRead_control  input  1  load request from the core.
REQ-006 SHALL have port MemWrite_control  input  1  store request from the core.
REQ-007 SHALL have port Address  input  64  byte address (ALU result).
REQ-008 SHALL have port Write_data  input  64  store data (register data 2).
REQ-009 SHALL have port Read_data  output  64  registered load data.
REQ-010 SHALL have port Mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port Mem_busy  output  1  request in progress; new requests ignored.
REQ-012 SHALL have port Mem_error  output  1  error flag, valid only while Mem_ready is high.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP, with Mem_busy high in WAIT and RESP.
REQ-014 SHALL accept a request in IDLE only when exactly one of MemRead_control or MemWrite_control is high at a rising edge, capturing the operation, Address and Write_data at that edge.
REQ-015 SHALL leave the FSM in IDLE with memory unchanged and no response when both MemRead_control and MemWrite_control are high.
REQ-016 SHALL, on accept with WAIT_STATES>0, go to WAIT and load a counter with WAIT_STATES-1; WAIT SHALL decrement the counter each edge and go to RESP on the edge at which it is 0.
REQ-017 SHALL, on accept with WAIT_STATES=0, go directly to RESP.
REQ-018 SHALL commit a store to the array, or register the load data into Read_data, on the edge that enters RESP.
REQ-019 SHALL hold Mem_ready high for exactly the one RESP cycle, then return to IDLE.
REQ-020 SHALL produce Mem_ready exactly WAIT_STATES+1 cycles after the accept edge.
REQ-021 SHALL accept a request present on the RESP-to-IDLE edge no earlier than the following edge (IDLE must be observed).
REQ-022 SHALL form the word index from Address[log2(DEPTH)+2:3]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*8.
REQ-023 SHALL ignore all request inputs while in WAIT or RESP, including changes to the captured operands.
REQ-024 SHALL hold Read_data unchanged after stores and between loads, updating it only on load completion.

Reset
REQ-025 SHALL, while RESET_N is low, immediately force the state to IDLE, the counter to 0, Read_data to 0, Mem_ready to 0, Mem_busy to 0, Mem_error to 0, and every array word to 0.
REQ-026 SHALL abort an in-flight request when reset is asserted mid-operation, with no store committed and no Mem_ready produced for it.
REQ-027 SHALL accept the first request on the first rising edge after RESET_N rises.

Configuration
REQ-028 SHALL, with macro DMEM_ALIGN_CHECK_EN defined, treat a request with Address[2:0]!=0 as misaligned: it follows normal timing, performs no store, leaves Read_data unchanged, and raises Mem_error together with Mem_ready.
REQ-029 SHALL, without DMEM_ALIGN_CHECK_EN, ignore Address[2:0] and hold the Mem_error port at 0, keeping the port list unchanged.

Verification
REQ-030 SHALL verify a store followed by a load: WAIT_STATES=2, store 0xDEADBEEF_CAFEF00D to address 0x40, then load from 0x40 -> Mem_ready exactly 3 cycles after each accept, and Read_data = 0xDEADBEEF_CAFEF00D.
REQ-031 SHALL verify wrap-around: DEPTH=32, store 0x1234 to address 0x100, then load from 0x0 -> Read_data = 0x1234.
REQ-032 SHALL verify simultaneous requests: MemRead_control and MemWrite_control both high for 4 cycles -> Mem_busy stays 0, no Mem_ready, and a subsequent load from the same address returns the old value.
REQ-033 SHALL verify reset mid-operation: store 0x55 to address 0x8 and pull RESET_N low in WAIT -> outputs are 0 at once, and a subsequent load from 0x8 returns 0.
REQ-034 SHALL verify zero wait states: WAIT_STATES=0 with back-to-back loads held high -> Mem_ready on every other cycle, with latency 1.
REQ-035 SHALL verify misalignment: with DMEM_ALIGN_CHECK_EN defined, store to address 0x43 -> Mem_error=1 with Mem_ready, and word 8 is unchanged; without the macro, the same store writes word 8 and Mem_error=0.
